// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: controller state encoding shared by the bit-serial adder.
package serial_add_ctrl_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_add_ctrl_fa2.sv
// fa2: one-bit full-adder cell time-shared by the serial controller.
module fa2 (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract over one fa2 cell, LSB first, with valid/ready on both sides.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    state_t           state, next_state;
    logic [WIDTH-1:0] ra, rb, acc_next;
    logic [WIDTH-2:0] acc;
    logic [CW-1:0]    cnt;
    logic             carry, fa_s, fa_c, run, done, last, accept;

    assign run       = state == S_RUN;
    assign done      = state == S_DONE;
    assign last      = run && cnt == CW'(WIDTH - 1);
    assign in_ready  = !(run || done);
    assign out_valid = done;
    assign accept    = in_valid && in_ready;
    // Partial sum fills from the top; the incoming bit completes the word on the last cycle.
    assign acc_next  = {fa_s, acc};

    fa2 u_fa (
        .a    (ra[0]),
        .b    (rb[0]),
        .c_in (carry),
        .s    (fa_s),
        .c_out(fa_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Encoding 2'd3 falls through to the idle arm.
    always_comb begin
        next_state = run  ? (last ? S_DONE : S_RUN) :
                     done ? (out_ready ? S_IDLE : S_DONE) :
                            (in_valid ? S_RUN : S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra    <= '0;
            rb    <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            ra    <= a;
            rb    <= b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
        end else if (run) begin
            ra    <= ra >> 1;
            rb    <= rb >> 1;
            acc   <= acc_next[WIDTH-1:1];
            carry <= fa_c;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum   <= acc_next;
                c_out <= fa_c;
                ovf   <= carry ^ fa_c;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of the serial adder at WIDTH 8 and 32
// against an arithmetic model of unsigned/signed add and subtract.
module tb_serial_add_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid8, in_ready8, sub8, out_valid8, out_ready8, c_out8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic        in_valid32, in_ready32, sub32, out_valid32, out_ready32, c_out32, ovf32;
    logic [31:0] a32, b32, sum32;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
        .c_out(c_out8), .ovf(ovf8)
    );

    serial_add_ctrl #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .b(b32),
        .sub(sub32), .out_valid(out_valid32), .out_ready(out_ready32), .sum(sum32),
        .c_out(c_out32), .ovf(ovf32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic sv, output logic [31:0] s, output logic co,
                                  output logic ov);
        longint m    = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua   = longint'(av) & m;
        longint ub   = longint'(bv) & m;
        longint sa   = ua >= half ? ua - (m + 1) : ua;
        longint sb   = ub >= half ? ub - (m + 1) : ub;
        longint r    = sv ? sa - sb : sa + sb;
        s  = 32'((sv ? ua - ub : ua + ub) & m);
        co = sv ? (ua >= ub) : (ua + ub > m);
        ov = (r >= half) || (r < -half);
    endfunction

    task automatic drive(input bit w, input logic [31:0] av, input logic [31:0] bv,
                         input logic sv, input logic v);
        if (w) begin
            in_valid32 = v; a32 = av; b32 = bv; sub32 = sv;
        end else begin
            in_valid8 = v; a8 = av[7:0]; b8 = bv[7:0]; sub8 = sv;
        end
    endtask

    task automatic set_ready(input bit w, input logic r);
        if (w) out_ready32 = r;
        else   out_ready8 = r;
    endtask

    task automatic start_op(input bit w, input logic [31:0] av, input logic [31:0] bv, input logic sv);
        int t = 0;
        while (!(w ? in_ready32 : in_ready8) && t < 200) begin
            @(posedge clk); #1; t++;
        end
        check("accept_ready", 64'(w ? in_ready32 : in_ready8), 64'd1);
        drive(w, av, bv, sv, 1'b1);
        @(posedge clk); #1;
        drive(w, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic finish_op(input bit w, input logic [31:0] av, input logic [31:0] bv, input logic sv);
        int          lat = 1;
        int          wd  = w ? 32 : 8;
        logic [31:0] es;
        logic        ec, eo;
        model(wd, av, bv, sv, es, ec, eo);
        while (!(w ? out_valid32 : out_valid8) && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        check(w ? "latency32" : "latency8", 64'(lat), 64'(wd + 1));
        check(w ? "sum32" : "sum8", 64'(w ? sum32 : 32'(sum8)), 64'(es));
        check(w ? "c_out32" : "c_out8", 64'(w ? c_out32 : c_out8), 64'(ec));
        check(w ? "ovf32" : "ovf8", 64'(w ? ovf32 : ovf8), 64'(eo));
    endtask

    task automatic release_op(input bit w, input int stall);
        logic [31:0] held = w ? sum32 : 32'(sum8);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        check("stall_valid", 64'(w ? out_valid32 : out_valid8), 64'd1);
        check("stall_sum", 64'(w ? sum32 : 32'(sum8)), 64'(held));
        set_ready(w, 1'b1);
        @(posedge clk); #1;
        set_ready(w, 1'b0);
        check("release_valid", 64'(w ? out_valid32 : out_valid8), 64'd0);
        check("release_ready", 64'(w ? in_ready32 : in_ready8), 64'd1);
    endtask

    task automatic op(input bit w, input logic [31:0] av, input logic [31:0] bv,
                      input logic sv, input int stall);
        start_op(w, av, bv, sv);
        finish_op(w, av, bv, sv);
        release_op(w, stall);
    endtask

    initial begin
        logic [7:0] held;
        logic       seen;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        out_ready8 = 1'b0;
        out_ready32 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready8), 64'd1);
        check("rst_out_valid", 64'(out_valid8), 64'd0);
        check("rst_sum", 64'(sum8), 64'd0);
        check("rst_c_out", 64'(c_out8), 64'd0);
        check("rst_ovf", 64'(ovf8), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        op(0, 32'h05, 32'h03, 1'b0, 0);
        check("t1_sum", 64'(sum8), 64'h08);
        op(0, 32'hFF, 32'h01, 1'b0, 1);
        check("t2a_sum", 64'(sum8), 64'h00);
        check("t2a_c_out", 64'(c_out8), 64'd1);
        op(0, 32'h7F, 32'h01, 1'b0, 0);
        check("t2b_sum", 64'(sum8), 64'h80);
        check("t2b_ovf", 64'(ovf8), 64'd1);
        op(0, 32'h03, 32'h05, 1'b1, 0);
        check("t3a_sum", 64'(sum8), 64'hFE);
        check("t3a_c_out", 64'(c_out8), 64'd0);
        op(0, 32'h80, 32'h01, 1'b1, 0);
        check("t3b_sum", 64'(sum8), 64'h7F);
        check("t3b_ovf", 64'(ovf8), 64'd1);

        // Backpressure with a competing operand that must be ignored.
        start_op(0, 32'h21, 32'h12, 1'b0);
        finish_op(0, 32'h21, 32'h12, 1'b0);
        held = sum8;
        drive(0, 32'hFF, 32'hFF, 1'b0, 1'b1);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(out_valid8), 64'd1);
            check("bp_sum", 64'(sum8), 64'(held));
            check("bp_in_ready", 64'(in_ready8), 64'd0);
        end
        drive(0, 32'h11, 32'h22, 1'b0, 1'b1);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check("bp_release_valid", 64'(out_valid8), 64'd0);
        check("bp_release_ready", 64'(in_ready8), 64'd1);
        check("bp_sum_held", 64'(sum8), 64'(held));
        @(posedge clk); #1;
        drive(0, 32'h00, 32'h00, 1'b0, 1'b0);
        finish_op(0, 32'h11, 32'h22, 1'b0);
        check("bp_next_sum", 64'(sum8), 64'h33);
        release_op(0, 0);

        // Asynchronous abort partway through RUN.
        start_op(0, 32'h55, 32'h66, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("abort_in_ready", 64'(in_ready8), 64'd1);
        check("abort_out_valid", 64'(out_valid8), 64'd0);
        check("abort_sum", 64'(sum8), 64'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            seen |= out_valid8;
        end
        check("abort_never_valid", 64'(seen), 64'd0);
        op(0, 32'h10, 32'h20, 1'b0, 0);
        check("abort_next_sum", 64'(sum8), 64'h30);

        for (int w = 0; w < 2; w++) begin
            repeat (1000) begin
                op(w[0], $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
